// File: rtl/cfg_pkg.sv
// Shared constants for the configuration packet controller: op codes, address
// types, default widths, packet field offsets and FSM state encoding.
package cfg_pkg;

  localparam int unsigned CFG_CDW   = 21;
  localparam int unsigned CFG_CAW   = 15;
  localparam int unsigned CFG_LW    = 4;
  localparam int unsigned CFG_PKT_W = 2 + CFG_LW + CFG_CAW + CFG_CDW;
  localparam int unsigned CFG_RSP_W = CFG_CAW + CFG_CDW;

  // Request packet layout: {op, len, addr, data}
  localparam int unsigned PKT_DATA_LSB = 0;
  localparam int unsigned PKT_ADDR_LSB = CFG_CDW;
  localparam int unsigned PKT_LEN_LSB  = CFG_CDW + CFG_CAW;
  localparam int unsigned PKT_OP_LSB   = CFG_CDW + CFG_CAW + CFG_LW;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_WR  = 2'b01,
    OP_RD  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  localparam logic [2:0] CFG_REG = 3'b000;
  localparam logic [2:0] WGT_MEM = 3'b001;
  localparam logic [2:0] DST_MEM = 3'b010;
  localparam logic [2:0] VM_MEM  = 3'b100;
  localparam logic [2:0] VM_BUF  = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_CAPT,
    ST_RD_WAIT
  } state_e;

  function automatic logic addr_type_unmapped(input logic [2:0] t);
    return !(t inside {CFG_REG, WGT_MEM, DST_MEM, VM_MEM, VM_BUF});
  endfunction

endpackage

// File: rtl/cfg_pkt_ctrl.sv
// Turns config request packets into configurator write/read strobes and returns
// read data as response packets. Define CFG_PKT_ERR_EN for error responses.
module cfg_pkt_ctrl
  import cfg_pkg::*;
#(
  parameter int unsigned CDW = CFG_CDW,
  parameter int unsigned CAW = CFG_CAW,
  parameter int unsigned LW  = CFG_LW,
  parameter int unsigned PKT_W = 2 + LW + CAW + CDW,
  parameter int unsigned RSP_W = CAW + CDW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic [PKT_W-1:0] pkt_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RSP_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic             config_we,
  output logic [CAW-1:0]   config_waddr,
  output logic [CDW-1:0]   config_wdata,
  output logic             config_re,
  output logic [CAW-1:0]   config_raddr,
  input  logic [CDW-1:0]   config_rdata,
  output logic             busy
);

  state_e state_q, state_d;
  logic [CAW-1:0] addr_q, addr_d;
  logic [LW-1:0]  cnt_q, cnt_d;

  logic           we_d, re_d;
  logic [CAW-1:0] waddr_d, raddr_d;
  logic [CDW-1:0] wdata_d;
  logic           rsp_valid_d;
  logic [RSP_W-1:0] rsp_data_d;

  op_e            pkt_op;
  logic [LW-1:0]  pkt_len;
  logic [CAW-1:0] pkt_addr;
  logic [CDW-1:0] pkt_wdata;

  assign pkt_op    = op_e'(pkt_data[PKT_W-1 -: 2]);
  assign pkt_len   = pkt_data[CDW+CAW +: LW];
  assign pkt_addr  = pkt_data[CDW +: CAW];
  assign pkt_wdata = pkt_data[0 +: CDW];

  assign pkt_ready = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);

`ifdef CFG_PKT_ERR_EN
  logic err_q, err_d;
  logic rsp_err_q, rsp_err_d;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Every strobe and response field is computed here as the value it takes
  // next cycle, so all config_* and rsp_* outputs leave straight from flops.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    waddr_d     = config_waddr;
    wdata_d     = config_wdata;
    raddr_d     = config_raddr;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
`ifdef CFG_PKT_ERR_EN
    err_d       = err_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pkt_valid) begin
          case (pkt_op)
            OP_WR: begin
              state_d = ST_WR;
              we_d    = 1'b1;
              waddr_d = pkt_addr;
              wdata_d = pkt_wdata;
            end
            OP_RD: begin
              state_d = ST_RD_ISSUE;
              re_d    = 1'b1;
              raddr_d = pkt_addr;
              addr_d  = pkt_addr;
              cnt_d   = pkt_len;
`ifdef CFG_PKT_ERR_EN
              err_d   = addr_type_unmapped(pkt_addr[CAW-1 -: 3]);
`endif
            end
`ifdef CFG_PKT_ERR_EN
            OP_RSV: begin
              state_d     = ST_RD_WAIT;
              addr_d      = pkt_addr;
              cnt_d       = '0;
              rsp_valid_d = 1'b1;
              rsp_data_d  = {pkt_addr, {CDW{1'b1}}};
              rsp_err_d   = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_WR:       state_d = ST_IDLE;
      ST_RD_ISSUE: state_d = ST_RD_CAPT;
      ST_RD_CAPT: begin
        state_d     = ST_RD_WAIT;
        rsp_valid_d = 1'b1;
        rsp_data_d  = {addr_q, config_rdata};
`ifdef CFG_PKT_ERR_EN
        rsp_err_d   = err_q;
`endif
      end
      ST_RD_WAIT: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef CFG_PKT_ERR_EN
          rsp_err_d   = 1'b0;
`endif
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RD_ISSUE;
            cnt_d   = cnt_q - 1'b1;
            addr_d  = addr_q + 1'b1;
            raddr_d = addr_q + 1'b1;
            re_d    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      config_we    <= 1'b0;
      config_re    <= 1'b0;
      config_waddr <= '0;
      config_wdata <= '0;
      config_raddr <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
`ifdef CFG_PKT_ERR_EN
      err_q        <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      config_we    <= we_d;
      config_re    <= re_d;
      config_waddr <= waddr_d;
      config_wdata <= wdata_d;
      config_raddr <= raddr_d;
      rsp_valid    <= rsp_valid_d;
      rsp_data     <= rsp_data_d;
`ifdef CFG_PKT_ERR_EN
      err_q        <= err_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_cfg_pkt_ctrl.sv
// Scoreboard bench for cfg_pkt_ctrl: expected strobes and responses are queued
// by the stimulus and popped by independent monitors.
module tb_cfg_pkt_ctrl;
  import cfg_pkg::*;

  localparam int unsigned CDW   = CFG_CDW;
  localparam int unsigned CAW   = CFG_CAW;
  localparam int unsigned LW    = CFG_LW;
  localparam int unsigned PKT_W = CFG_PKT_W;
  localparam int unsigned RSP_W = CFG_RSP_W;

  typedef logic [RSP_W:0]       rsp_t;
  typedef logic [CAW+CDW:0]     cfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             pkt_valid = 1'b0;
  logic             pkt_ready;
  logic [PKT_W-1:0] pkt_data = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [RSP_W-1:0] rsp_data;
  logic             rsp_err;
  logic             config_we;
  logic [CAW-1:0]   config_waddr;
  logic [CDW-1:0]   config_wdata;
  logic             config_re;
  logic [CAW-1:0]   config_raddr;
  logic [CDW-1:0]   config_rdata = '0;
  logic             busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  rsp_t rsp_q[$];
  cfg_t cfg_q[$];

  cfg_pkt_ctrl #(.CDW(CDW), .CAW(CAW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .config_we(config_we), .config_waddr(config_waddr), .config_wdata(config_wdata),
    .config_re(config_re), .config_raddr(config_raddr), .config_rdata(config_rdata),
    .busy(busy)
  );

  // Configurator memory model: read data = address + 5, one cycle after the strobe
  always @(posedge clk) begin
    if (config_re) config_rdata <= CDW'(config_raddr) + CDW'(5);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic cfg_t exp_we(input logic [CAW-1:0] a, input logic [CDW-1:0] d);
    return {1'b1, a, d};
  endfunction
  function automatic cfg_t exp_re(input logic [CAW-1:0] a);
    return {1'b0, a, {CDW{1'b0}}};
  endfunction
  function automatic rsp_t exp_rsp(input logic e, input logic [CAW-1:0] a, input logic [CDW-1:0] d);
    return {e, a, d};
  endfunction

  // Strobe monitor
  always @(negedge clk) begin
    if (!rst && (config_we || config_re)) begin
      cfg_t act;
      act = config_we ? {1'b1, config_waddr, config_wdata} : {1'b0, config_raddr, {CDW{1'b0}}};
      chk("we_re_exclusive", {63'd0, config_we && config_re}, 64'd0);
      if (cfg_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL cfg_unexpected: got strobe 0x%0h, expected none", act);
      end else begin
        chk("cfg_strobe", 64'(act), 64'(cfg_q.pop_front()));
      end
    end
  end

  // Response monitor: compares on each handshake
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_t act;
      act = {rsp_err, rsp_data};
      if (rsp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_unexpected: got 0x%0h, expected none", act);
      end else begin
        chk("rsp", 64'(act), 64'(rsp_q.pop_front()));
      end
    end
  end

  // Stall monitor: data held while valid && !ready
  logic             stall_prev = 1'b0;
  logic [RSP_W-1:0] stall_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", {63'd0, rsp_valid}, 64'd1);
        chk("stall_data", 64'(rsp_data), 64'(stall_data));
      end
      stall_prev = rsp_valid && !rsp_ready;
      stall_data = rsp_data;
    end
  end

  task automatic send(input op_e op, input logic [LW-1:0] len,
                      input logic [CAW-1:0] a, input logic [CDW-1:0] d);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    pkt_valid = 1'b1;
    pkt_data  = {op, len, a, d};
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (pkt_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    pkt_valid = 1'b0;
    chk("pkt_accepted", {63'd0, done}, 64'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && !rsp_valid && cfg_q.size() == 0 && rsp_q.size() == 0;
    end
    chk(name, {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_rsp_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    chk(name, {63'd0, seen}, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pkt_ready", {63'd0, pkt_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_config_we", {63'd0, config_we}, 64'd0);
    chk("rst_config_re", {63'd0, config_re}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_pkt_ready", {63'd0, pkt_ready}, 64'd1);

    // 1: single write, strobe only at T+1, ready again at T+2
    cfg_q.push_back(exp_we(15'h0001, 21'h000100));
    send(OP_WR, 4'h0, 15'h0001, 21'h000100);
    @(negedge clk);
    chk("wr_we_t1", {63'd0, config_we}, 64'd1);
    chk("wr_ready_t1", {63'd0, pkt_ready}, 64'd0);
    @(negedge clk);
    chk("wr_we_t2", {63'd0, config_we}, 64'd0);
    chk("wr_ready_t2", {63'd0, pkt_ready}, 64'd1);
    wait_idle("wr_done");

    // 2: burst read len=2, first response at T+3
    cfg_q.push_back(exp_re(15'h1000));
    cfg_q.push_back(exp_re(15'h1001));
    cfg_q.push_back(exp_re(15'h1002));
    rsp_q.push_back(exp_rsp(1'b0, 15'h1000, 21'h001005));
    rsp_q.push_back(exp_rsp(1'b0, 15'h1001, 21'h001006));
    rsp_q.push_back(exp_rsp(1'b0, 15'h1002, 21'h001007));
    send(OP_RD, 4'd2, 15'h1000, 21'h0);
    @(negedge clk);
    chk("rd_re_t1", {63'd0, config_re}, 64'd1);
    chk("rd_valid_t1", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    chk("rd_valid_t2", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    chk("rd_valid_t3", {63'd0, rsp_valid}, 64'd1);
    wait_idle("rd_burst_done");

    // 3: same read with a 5-cycle consumer stall
    cfg_q.push_back(exp_re(15'h1000));
    cfg_q.push_back(exp_re(15'h1001));
    cfg_q.push_back(exp_re(15'h1002));
    rsp_q.push_back(exp_rsp(1'b0, 15'h1000, 21'h001005));
    rsp_q.push_back(exp_rsp(1'b0, 15'h1001, 21'h001006));
    rsp_q.push_back(exp_rsp(1'b0, 15'h1002, 21'h001007));
    rsp_ready = 1'b0;
    send(OP_RD, 4'd2, 15'h1000, 21'h0);
    wait_rsp_valid("stall_first_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_no_re", {63'd0, config_re}, 64'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_idle("stall_burst_done");

    // 4: address wrap 0x7FFF -> 0x0000
    cfg_q.push_back(exp_re(15'h7FFF));
    cfg_q.push_back(exp_re(15'h0000));
    rsp_q.push_back(exp_rsp(1'b0, 15'h7FFF, 21'h008004));
    rsp_q.push_back(exp_rsp(1'b0, 15'h0000, 21'h000005));
    send(OP_RD, 4'd1, 15'h7FFF, 21'h0);
    wait_idle("wrap_done");

    // 5: reset while a response is pending in a len=3 burst
    cfg_q.push_back(exp_re(15'h0200));
    rsp_ready = 1'b0;
    send(OP_RD, 4'd3, 15'h0200, 21'h0);
    wait_rsp_valid("rst_mid_valid");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {63'd0, pkt_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_re", {63'd0, config_re}, 64'd0);
    chk("rst_mid_ready_after", {63'd0, pkt_ready}, 64'd1);
    cfg_q.push_back(exp_we(15'h0042, 21'h1ABCD));
    send(OP_WR, 4'hF, 15'h0042, 21'h1ABCD);
    wait_idle("rst_mid_wr_done");

    // 6: NOP dropped; reserved op depends on the error feature
    send(OP_NOP, 4'h0, 15'h0555, 21'h0);
    wait_idle("nop_done");
`ifdef CFG_PKT_ERR_EN
    rsp_q.push_back(exp_rsp(1'b1, 15'h0123, 21'h1FFFFF));
`endif
    send(OP_RSV, 4'h0, 15'h0123, 21'h0);
    wait_idle("rsv_done");
`ifdef CFG_PKT_ERR_EN
    cfg_q.push_back(exp_re(15'h3004));
    rsp_q.push_back(exp_rsp(1'b1, 15'h3004, 21'h003009));
    send(OP_RD, 4'd0, 15'h3004, 21'h0);
    wait_idle("unmapped_rd_done");
`endif

    repeat (3) @(negedge clk);
    chk("cfg_q_empty", 64'(cfg_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
